// File: rtl/lift_sched.sv
`default_nettype none
// lift_sched: collective/SCAN lift car scheduler with door sequencing and sticky door-timeout fault.
// Define LIFT_SCHED_ESTOP_EN to add the estop input and the HALT state.
module lift_sched #(
  parameter int FLOORS       = 8,
  parameter int MOVE_TIME    = 20,
  parameter int DOOR_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOORS-1:0] req,
  input  logic              r,
  input  logic              door_closed,
`ifdef LIFT_SCHED_ESTOP_EN
  input  logic              estop,
`endif
  output logic              open_signal,
  output logic              up,
  output logic              down,
  output logic [2:0]        floor,
  output logic [FLOORS-1:0] pending,
  output logic              fault
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MOVE      = 3'd1,
    ARRIVE    = 3'd2,
    DOOR_OPEN = 3'd3,
`ifdef LIFT_SCHED_ESTOP_EN
    DOOR_WAIT = 3'd4,
    HALT      = 3'd5
`else
    DOOR_WAIT = 3'd4
`endif
  } state_t;

  state_t            state, state_n;
  logic              dir, dir_n;
  logic [7:0]        cnt, cnt_n;
  logic [2:0]        floor_n;
  logic [FLOORS-1:0] pending_n;
  logic              fault_n;

  logic       above, below, ahead, behind, here, req_here;
  logic [7:0] pend8, req8, latch_mask, clear_mask;

  assign pend8    = 8'(pending);
  assign req8     = 8'(req);
  assign here     = pend8[floor];
  assign req_here = req8[floor];

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (pending[i] && (3'(i) > floor)) above = 1'b1;
      if (pending[i] && (3'(i) < floor)) below = 1'b1;
    end
  end

  assign ahead  = dir ? above : below;
  assign behind = dir ? below : above;

  always_comb begin
    state_n    = state;
    dir_n      = dir;
    cnt_n      = cnt;
    floor_n    = floor;
    fault_n    = fault;
    latch_mask = 8'hFF;
    clear_mask = 8'hFF;

    case (state)
      IDLE: begin
        cnt_n = 8'd0;
        if (here) begin
          state_n = DOOR_OPEN;
        end else if (ahead) begin
          state_n = MOVE;
        end else if (behind) begin
          dir_n   = !dir;
          state_n = MOVE;
        end
      end
      MOVE: begin
        if (cnt == 8'(MOVE_TIME - 1)) begin
          cnt_n   = 8'd0;
          floor_n = dir ? floor + 3'd1 : floor - 3'd1;
          state_n = ARRIVE;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      ARRIVE: begin
        cnt_n = 8'd0;
        if (here)       state_n = DOOR_OPEN;
        else if (ahead) state_n = MOVE;
        else            state_n = IDLE;
      end
      DOOR_OPEN: begin
        cnt_n             = 8'd0;
        clear_mask[floor] = 1'b0;
        state_n           = DOOR_WAIT;
      end
      DOOR_WAIT: begin
        // A call for this floor while the door is still open is served by reopening, not latched.
        if (!door_closed) latch_mask[floor] = 1'b0;
        if (door_closed) begin
          state_n = IDLE;
        end else if (r || req_here) begin
          state_n = DOOR_OPEN;
        end else begin
          if (cnt != 8'hFF) cnt_n = cnt + 8'd1;
          if (32'(cnt) == DOOR_TIMEOUT) fault_n = 1'b1;
        end
      end
`ifdef LIFT_SCHED_ESTOP_EN
      HALT: begin
        cnt_n = 8'd0;
        if (!estop) state_n = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase

    pending_n = (pending | (req & latch_mask[FLOORS-1:0])) & clear_mask[FLOORS-1:0];

`ifdef LIFT_SCHED_ESTOP_EN
    if (estop) begin
      state_n = HALT;
      cnt_n   = 8'd0;
    end
    if (estop || (state == HALT)) pending_n = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      dir     <= 1'b1;
      cnt     <= 8'd0;
      floor   <= 3'd0;
      pending <= '0;
      fault   <= 1'b0;
    end else begin
      state   <= state_n;
      dir     <= dir_n;
      cnt     <= cnt_n;
      floor   <= floor_n;
      pending <= pending_n;
      fault   <= fault_n;
    end
  end

  assign open_signal = (state == DOOR_OPEN);
  assign up          = (state == MOVE) && dir;
  assign down        = (state == MOVE) && !dir;

endmodule
`default_nettype wire
